// File: rtl/mult_acc_pkg.sv
// rtl/mult_acc_pkg.sv - shared types, defaults and width helper for the accumulation stage
package mult_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int ACC_W_DEF   = 16;
    localparam int N_TERMS_DEF = 4;

    // Term counter must be able to hold the value N_TERMS itself.
    function automatic int cnt_width(input int n_terms);
        return $clog2(n_terms + 1);
    endfunction

endpackage

// File: rtl/acc_add.sv
// rtl/acc_add.sv - accumulator adder with carry-out; saturating when MULT_ACC_SAT_EN is defined
module acc_add
    import mult_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [7:0]       prod,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

`ifdef MULT_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [ACC_W:0] full;

    // One extra bit of headroom exposes the carry; a saturated acc re-carries on any nonzero add, so it stays pinned.
    always_comb begin
        full  = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod};
        carry = full[ACC_W];
        sum   = (SAT && carry) ? {ACC_W{1'b1}} : full[ACC_W-1:0];
    end

endmodule

// File: rtl/main.sv
// rtl/main.sv - 4x4 unsigned multiplier whose product feeds the accumulation stage
module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);

    // Operands widened so the full 8-bit product is kept.
    assign o = {4'b0000, x} * {4'b0000, y};

endmodule

// File: rtl/mult_acc_stage.sv
// rtl/mult_acc_stage.sv - frames N_TERMS multiplier products into one sum (option: MULT_ACC_SAT_EN)
module mult_acc_stage
    import mult_acc_pkg::*;
#(
    parameter int  ACC_W   = ACC_W_DEF,
    parameter int  N_TERMS = N_TERMS_DEF,
    localparam int CW      = cnt_width(N_TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       prod,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CW-1:0]    out_cnt,
    output logic             out_ovf
);

    localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS);

    acc_state_t       state;
    logic [ACC_W-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;

    logic             accept;
    logic             frame_open;
    logic             close;
    logic [ACC_W-1:0] add_base;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [ACC_W-1:0] nxt_acc;
    logic [CW-1:0]    nxt_cnt;
    logic             nxt_ovf;

    assign accept     = in_valid && in_ready;
    assign frame_open = (cnt_q != '0);

    // First term of a frame starts from zero instead of the stale accumulator.
    always_comb begin
        add_base = frame_open ? acc_q : '0;
    end

    acc_add #(
        .ACC_W (ACC_W)
    ) u_acc_add (
        .acc   (add_base),
        .prod  (prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Next-state frame values and the close decision; close is only acted on in ACCUM.
    always_comb begin
        nxt_acc = acc_q;
        nxt_cnt = cnt_q;
        nxt_ovf = ovf_q;
        if (accept) begin
            nxt_acc = add_sum;
            nxt_cnt = cnt_q + CW'(1);
            nxt_ovf = (frame_open && ovf_q) || add_carry;
        end
        close = (accept && (nxt_cnt == LAST_CNT)) || (flush && (nxt_cnt != '0));
    end

    // Frame FSM: accumulate in ACCUM, present the result in HOLD until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_q <= nxt_acc;
                        cnt_q <= nxt_cnt;
                        ovf_q <= nxt_ovf;
                    end
                    if (close) begin
                        out_sum   <= nxt_acc;
                        out_cnt   <= nxt_cnt;
                        out_ovf   <= nxt_ovf;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        cnt_q     <= '0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_acc_stage.sv
// tb/tb_mult_acc_stage.sv - self-checking bench for mult_acc_stage fed by the main multiplier (option: MULT_ACC_SAT_EN)
module tb_mult_acc_stage;

`ifdef MULT_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        bit     vld;
        longint psum;
        int     pcnt;
        longint osum;
        int     ocnt;
        bit     oovf;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  a_x, a_y, b_x, b_y;
    logic [7:0]  a_prod, b_prod;
    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_ovf;
    logic [15:0] a_out_sum;
    logic [2:0]  a_out_cnt;
    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_ovf;
    logic [9:0]  b_out_sum;
    logic [3:0]  b_out_cnt;

    int     checks = 0;
    int     errors = 0;
    bit     collect = 1'b0;
    longint a_total = 0;
    mdl_t   ma, mb;

    always #5 clk = ~clk;

    main u_mul_a (.x(a_x), .y(a_y), .o(a_prod));
    main u_mul_b (.x(b_x), .y(b_y), .o(b_prod));

    mult_acc_stage u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .prod(a_prod),
        .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_cnt(a_out_cnt), .out_ovf(a_out_ovf)
    );

    mult_acc_stage #(.ACC_W(10), .N_TERMS(8)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .prod(b_prod),
        .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_cnt(b_out_cnt), .out_ovf(b_out_ovf)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level reference: exact running sum of accepted products, reduced only when a frame closes.
    function automatic mdl_t model_step(mdl_t m, int w, int n, bit r, bit iv, int p, bit fl, bit ordy);
        mdl_t   q;
        longint maxv;
        q    = m;
        maxv = (longint'(1) << w) - 1;
        if (r) begin
            q.vld  = 1'b0;
            q.psum = 0;
            q.pcnt = 0;
        end else if (m.vld) begin
            if (ordy) q.vld = 1'b0;
        end else begin
            if (iv) begin
                q.psum = q.psum + p;
                q.pcnt = q.pcnt + 1;
            end
            if ((iv && q.pcnt == n) || (fl && q.pcnt > 0)) begin
                q.oovf = (q.psum > maxv);
                q.ocnt = q.pcnt;
                q.osum = SAT ? (q.oovf ? maxv : q.psum) : (q.psum % (maxv + 1));
                q.vld  = 1'b1;
                q.psum = 0;
                q.pcnt = 0;
            end
        end
        return q;
    endfunction

    task automatic cmp_dut(input string nm, input mdl_t m, input bit ir, input bit ov,
                           input longint s, input int c, input bit o);
        chk({nm, "_in_ready"}, ir, !m.vld);
        chk({nm, "_out_valid"}, ov, m.vld);
        if (m.vld) begin
            chk({nm, "_out_sum"}, s, m.osum);
            chk({nm, "_out_cnt"}, c, m.ocnt);
            chk({nm, "_out_ovf"}, o, m.oovf);
        end
    endtask

    // Every cycle: compare both DUTs against the model, then advance the model with this cycle's inputs.
    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        forever begin
            @(negedge clk);
            cmp_dut("a", ma, a_in_ready, a_out_valid, a_out_sum, a_out_cnt, a_out_ovf);
            cmp_dut("b", mb, b_in_ready, b_out_valid, b_out_sum, b_out_cnt, b_out_ovf);
            if (collect && a_out_valid && a_out_ready) a_total = a_total + a_out_sum;
            ma = model_step(ma, 16, 4, rst, a_in_valid, a_prod, a_flush, a_out_ready);
            mb = model_step(mb, 10, 8, rst, b_in_valid, b_prod, b_flush, b_out_ready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input logic [3:0] x, input logic [3:0] y);
        a_in_valid = 1'b1;
        a_x = x;
        a_y = y;
        tick();
    endtask

    task automatic put_b(input logic [3:0] x, input logic [3:0] y);
        b_in_valid = 1'b1;
        b_x = x;
        b_y = y;
        tick();
    endtask

    task automatic lit_a(input string nm, input bit v, input bit ir, input longint s, input int c, input bit o);
        chk({nm, "_valid"}, a_out_valid, v);
        chk({nm, "_ready"}, a_in_ready, ir);
        if (v) begin
            chk({nm, "_sum"}, a_out_sum, s);
            chk({nm, "_cnt"}, a_out_cnt, c);
            chk({nm, "_ovf"}, a_out_ovf, o);
        end
    endtask

    task automatic lit_reset(input string nm);
        lit_a(nm, 1'b0, 1'b1, 0, 0, 1'b0);
        chk({nm, "_sum0"}, a_out_sum, 0);
        chk({nm, "_cnt0"}, a_out_cnt, 0);
        chk({nm, "_ovf0"}, a_out_ovf, 0);
    endtask

    initial begin
        int idx;
        int cyc;
        bit acc_now;
        a_x = '0; a_y = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
        b_x = '0; b_y = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        lit_reset("reset");

        // 225 + 15 + 0 + 63 = 303, back to back
        put_a(15, 15); put_a(3, 5); put_a(0, 9); put_a(7, 9);
        a_in_valid = 1'b0;
        lit_a("frame4", 1'b1, 1'b0, 303, 4, 1'b0);
        tick();
        lit_a("frame4_done", 1'b0, 1'b1, 0, 0, 1'b0);

        // 10 + 20 closed by flush, result held while consumer stalls
        a_out_ready = 1'b0;
        put_a(2, 5); put_a(4, 5);
        a_in_valid = 1'b0;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        lit_a("flush2", 1'b1, 1'b0, 30, 2, 1'b0);
        a_in_valid = 1'b1; a_x = 9; a_y = 11; a_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit_a("flush2_hold", 1'b1, 1'b0, 30, 2, 1'b0);
        end
        a_out_ready = 1'b1; a_in_valid = 1'b0; a_flush = 1'b0;
        tick();
        lit_a("flush2_done", 1'b0, 1'b1, 0, 0, 1'b0);

        // flush together with the first accept, then flush on an empty frame
        a_in_valid = 1'b1; a_x = 7; a_y = 1; a_flush = 1'b1;
        tick();
        a_in_valid = 1'b0; a_flush = 1'b0;
        lit_a("flush1", 1'b1, 1'b0, 7, 1, 1'b0);
        tick();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        lit_a("flush_empty", 1'b0, 1'b1, 0, 0, 1'b0);
        tick();
        lit_a("flush_empty2", 1'b0, 1'b1, 0, 0, 1'b0);

        // reset mid-frame, fresh frame 1+2+3+4, then reset while holding
        put_a(5, 1); put_a(6, 1);
        a_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lit_reset("rst_mid");
        a_out_ready = 1'b0;
        put_a(1, 1); put_a(2, 1); put_a(3, 1); put_a(4, 1);
        a_in_valid = 1'b0;
        lit_a("after_rst", 1'b1, 1'b0, 10, 4, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lit_reset("rst_hold");
        a_out_ready = 1'b1;

        // narrow accumulator: 8 x 225 = 1800 overflows 10 bits
        for (int i = 0; i < 8; i++) put_b(15, 15);
        b_in_valid = 1'b0;
        chk("b_ovf_valid", b_out_valid, 1);
        chk("b_ovf_sum", b_out_sum, SAT ? 1023 : 776);
        chk("b_ovf_cnt", b_out_cnt, 8);
        chk("b_ovf_flag", b_out_ovf, 1);
        tick();
        for (int i = 0; i < 8; i++) put_b(1, 1);
        b_in_valid = 1'b0;
        chk("b_next_sum", b_out_sum, 8);
        chk("b_next_ovf", b_out_ovf, 0);
        tick();

        // every x*y pair pushed once under random valid, flush and backpressure
        collect = 1'b1;
        a_total = 0;
        idx = 0;
        cyc = 0;
        while (idx < 256 && cyc < 4000) begin
            a_in_valid  = ($urandom % 2) == 0;
            a_x         = idx[3:0];
            a_y         = idx[7:4];
            a_flush     = ($urandom % 8) == 0;
            a_out_ready = ($urandom % 3) != 0;
            acc_now     = a_in_valid && a_in_ready;
            tick();
            if (acc_now) idx++;
            cyc++;
        end
        chk("rand_terms", idx, 256);
        a_in_valid = 1'b0; a_flush = 1'b1; a_out_ready = 1'b1;
        tick();
        a_flush = 1'b0;
        repeat (3) tick();
        collect = 1'b0;
        chk("rand_total", a_total, 14400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_acc_stage.md
# mult_acc_stage

Sequential accumulation stage sitting directly downstream of the 4x4 unsigned multiplier (`main`). It consumes the multiplier's 8-bit product `o` under a valid/ready handshake and sums `N_TERMS` products into one frame. It presents each frame's sum with a term count and an overflow flag on a valid/ready output port. This turns the combinational multiplier into a dot-product / MAC datapath.

## Interface
- `ACC_W`, default 16: accumulator and `out_sum` width; legal range ≥ 8.
- `N_TERMS`, default 4: products per frame; legal range ≥ 1.
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: `prod` is valid.
- `in_ready` out 1: stage accepts a product this cycle.
- `prod` in 8: unsigned product from the multiplier output `o`.
- `flush` in 1: close the current frame early.
- `out_valid` out 1: frame result is valid.
- `out_ready` in 1: consumer takes the result.
- `out_sum` out ACC_W: frame sum.
- `out_cnt` out CW: number of terms in the frame, where CW = $clog2(N_TERMS+1).
- `out_ovf` out 1: sum exceeded 2^ACC_W − 1 at some point in the frame.

## Operation
- FSM states are `ACCUM` and `HOLD`. Reset state is `ACCUM`.
- An accept occurs when `in_valid && in_ready`.
- `in_ready` = 1 in `ACCUM` and 0 in `HOLD`. It is registered.
- Accumulate rule on accept:
  - acc_next = (cnt==0 ? 0 : acc) + prod, where `prod` is zero-extended to ACC_W+1 bits.
  - cnt_next = cnt + 1.
  - ovf_next = (cnt==0 ? 0 : ovf) | carry-out of the add.
- Frame close: on the accept that makes cnt_next == N_TERMS, or on `flush` when (cnt>0 or an accept occurs that cycle). On close:
  - Load `out_sum`, `out_cnt` and `out_ovf` from the next-state values.
  - Set `out_valid` = 1 and move to `HOLD`.
  - Clear the internal cnt.
- `flush` in `ACCUM` with cnt==0 and no accept: ignored, no empty frame is emitted.
- `flush` in `HOLD`: ignored, not latched.
- In `HOLD`, when `out_valid && out_ready`: clear `out_valid`, set `in_ready` = 1 and return to `ACCUM`.
- `out_sum`, `out_cnt` and `out_ovf` hold stable from the `out_valid` rise until the handshake completes.
- Without saturation, the sum wraps modulo 2^ACC_W.
- `N_TERMS`=1: every accept closes a frame.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_cnt`=0, `out_ovf`=0.
- Reset also clears acc and cnt and sets state to `ACCUM`.
- Reset mid-frame or in `HOLD` discards the partial frame or pending result.
- Accept-to-accept throughput is 1 product per cycle within a frame.
- `out_valid` rises in the cycle after the closing accept or flush, i.e. 1-cycle latency.
- Minimum frame period is N_TERMS + 1 cycles:
  - The output handshake and a new accept never share a cycle.
  - The first product of the next frame is accepted no earlier than the cycle after `out_ready` is sampled high.
- `prod` is sampled only on accept. Its value is don't-care otherwise.

## Configuration
- `MULT_ACC_SAT_EN` defined:
  - On carry-out, acc saturates to 2^ACC_W − 1 and stays there for the rest of the frame.
  - `out_ovf` is still set.
- `MULT_ACC_SAT_EN` undefined: wrap-around as described above; `out_ovf` is sticky per frame.

## Structure
- Package `mult_acc_pkg`:
  - state typedef `acc_state_t` {`ACCUM`, `HOLD`};
  - function computing CW from `N_TERMS`;
  - default constants `ACC_W_DEF`=16 and `N_TERMS_DEF`=4.
- Sub-module `acc_add`: combinational ACC_W-bit add of acc plus 8-bit zero-extended `prod`. It produces the sum and carry, and applies saturation under `MULT_ACC_SAT_EN`.
- The FSM and registers live in `mult_acc_stage`.
- Bench drives `prod` from a `main` instance to cover the multiplier→stage path.

## Test plan
- Defaults, back-to-back `prod` = 225, 15, 0, 63, with `out_ready`=1 → one cycle after the 4th accept: `out_valid`=1, `out_sum`=303, `out_cnt`=4, `out_ovf`=0; `in_ready` low for exactly 1 cycle.
- Products 10, 20, then `flush` with no valid; `out_ready` held 0 for 3 cycles → `out_sum`=30, `out_cnt`=2, outputs stable while held, `in_ready`=0 until the handshake.
- ACC_W=10, N_TERMS=8, eight products of 225 (sum 1800) → without the macro: `out_sum`=776, `out_ovf`=1; with `MULT_ACC_SAT_EN`: `out_sum`=1023, `out_ovf`=1. Next frame of 1,1,…: `out_ovf`=0.
- `flush` coincident with an accept of 7 as the first term → `out_sum`=7, `out_cnt`=1. `flush` alone at cnt=0 → no `out_valid`.
- Assert `rst` after 2 accepts, then deassert → all outputs at reset values. Next 4 products (1,2,3,4) give `out_sum`=10, `out_cnt`=4.
- `in_valid` toggled randomly with `x`,`y` sweeping 0..15 through `main` → every `out_sum` equals the reference-model sum of the products, with no lost or duplicated terms.
